fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the MIPS datapath. Holds the PC and drives the
//   byte-addressed, zero-latency instruction memory address. Latches the returned
//   word, its PC and PC+4 into the IF/ID pipeline register.
//   Handles stall, flush and branch/jump redirect from the hazard and EX logic.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset (word aligned)
//   NOP_INSTR  32'h0000_0000  word placed in IF/ID on bubble/reset (sll $0,$0,0)
// PORTS
//   clk          in   1   system clock, all state updates on posedge
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   hold PC and IF/ID contents (load-use hazard)
//   flush        in   1   replace IF/ID with bubble this cycle
//   redirect     in   1   taken branch/jump: load redirect_pc into PC
//   redirect_pc  in   32  branch/jump target byte address
//   imem_addr    out  32  address to instruction memory (= PC, combinational)
//   imem_instr   in   32  instruction word returned by memory, same cycle
//   ifid_pc      out  32  PC of instruction held in IF/ID
//   ifid_pc4     out  32  ifid_pc + 4
//   ifid_instr   out  32  instruction held in IF/ID
//   ifid_valid   out  1   1 = IF/ID holds a real instruction, 0 = bubble
//   fetch_count  out  32  number of valid instructions latched into IF/ID
//   misalign     out  1   sticky: a redirect_pc with [1:0]!=0 was accepted
// BEHAVIOUR
//   - Reset (rst=1 at posedge) results:
//     - pc=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR.
//     - ifid_valid=0, fetch_count=0, misalign=0.
//     - rst overrides all other inputs.
//   - imem_addr = pc combinationally. The word fetched in cycle N appears on ifid_*
//     after posedge N+1. Fetch latency is 1 cycle.
//   - Priority per posedge: rst > redirect > stall > normal. flush applies only to IF/ID.
//   - Normal (no stall/flush/redirect) updates:
//     - pc <= pc+4
//     - IF/ID <= {pc, pc+4, imem_instr}
//     - ifid_valid <= 1
//   - stall=1 (no redirect) holds pc and all IF/ID fields. With flush=1 also asserted,
//     IF/ID takes the bubble while pc still holds.
//   - flush=1 (no redirect, no stall) results:
//     - pc <= pc+4
//     - ifid_instr <= NOP_INSTR, ifid_valid <= 0
//     - ifid_pc and ifid_pc4 are loaded normally (debug only)
//   - redirect=1 results:
//     - pc <= {redirect_pc[31:2],2'b00}.
//     - IF/ID takes the bubble, because the word fetched this cycle is wrong-path.
//     - Overrides stall and flush.
//     - If redirect_pc[1:0]!=0, misalign <= 1 (stays set until rst).
//   - Arithmetic is mod 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0. No error is raised.
//   - fetch_count increments by 1 on each posedge where ifid_valid is written 1.
//     It saturates at 32'hFFFF_FFFF. A held (stalled) valid word is not re-counted.
//   - rst asserted mid-stall or coincident with redirect: reset values win and the
//     redirect is discarded.
//   - No combinational path exists from stall/flush/redirect to imem_addr. Only pc drives it.
// TESTING
//   1 rst 2 cyc, then free-run with imem words W0..W3 at 0,4,8,12 -> imem_addr
//     0,4,8,12; ifid_instr=W0 one cycle after addr 0, ifid_pc4=4, fetch_count=4 after 4 fetches
//   2 stall=1 for 3 cyc at pc=8 -> imem_addr stays 8, ifid_instr/pc frozen (W1,4),
//     fetch_count unchanged; release -> W2 latched next edge
//   3 redirect=1, redirect_pc=32'h40 at pc=12 -> next imem_addr=0x40, ifid_valid=0,
//     ifid_instr=NOP; following edge ifid_pc=0x40 valid
//   4 redirect=1 with stall=1, redirect_pc=32'h22 -> pc=0x20, misalign=1 and stays 1
//     until rst
//   5 flush=1 with stall=1 -> pc held, ifid_valid=0; flush alone -> pc+4, ifid_valid=0
//   6 RESET_PC=32'hFFFF_FFFC -> fetch at FFFF_FFFC then 0; rst with redirect -> pc=RESET_PC

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a zero-latency imem and
// fills the IF/ID register, honouring stall, flush and branch/jump redirect.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   stall                 hold PC and IF/ID (load-use hazard)
//   flush                 bubble into IF/ID this cycle
//   redirect, redirect_pc taken branch/jump and its target byte address
//   imem_addr             instruction memory address (= pc)
//   imem_instr            word returned by memory in the same cycle
//   ifid_pc, ifid_pc4     PC of the IF/ID word and PC+4
//   ifid_instr            IF/ID instruction word
//   ifid_valid            1 = real instruction, 0 = bubble
//   fetch_count           saturating count of valid words latched
//   misalign              sticky: a misaligned redirect target was taken
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [31:0] fetch_count,
    output logic        misalign
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        count_sat;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign count_sat = (fetch_count == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ifid_pc     <= 32'h0;
            ifid_pc4    <= 32'h0;
            ifid_instr  <= NOP_INSTR;
            ifid_valid  <= 1'b0;
            fetch_count <= 32'h0;
            misalign    <= 1'b0;
        end else if (redirect) begin
            // The word on imem_instr now is wrong-path: bubble it.
            pc         <= {redirect_pc[31:2], 2'b00};
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else if (stall) begin
            // PC and IF/ID addresses hold; flush may still kill the word.
            if (flush) begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end
        end else begin
            pc       <= pc_plus4;
            ifid_pc  <= pc;
            ifid_pc4 <= pc_plus4;
            if (flush) begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else begin
                ifid_instr <= imem_instr;
                ifid_valid <= 1'b1;
                if (!count_sat) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end
        end
    end

endmodule
